// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM link: state encoding and
// slot/miss-counter widths used by both receive and transmit sides.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SLOT_W     = 2;
  localparam int NUM_SLOTS  = 4;
  localparam int MISS_CNT_W = 3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Two-bit wrapping slot counter with enable, synchronous load-to-1 and
// synchronous clear; clear wins over load, load wins over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: locks onto the frame sync, assembles each frame
// in a shadow register and publishes the four channel bits with a strobe.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sync,
  input  logic en,
  output logic dout_0,
  output logic dout_1,
  output logic dout_2,
  output logic dout_3,
  output logic frame_valid,
  output logic sel_0,
  output logic sel_1,
  output logic locked,
  output logic sync_err
);

  state_t                  state, state_next;
  logic [SLOT_W-1:0]       slot;
  logic [NUM_SLOTS-2:0]    shadow, shadow_next;
  logic [NUM_SLOTS-1:0]    dout_q;
  logic [MISS_CNT_W-1:0]   miss_cnt, miss_next;
  logic                    cnt_inc, cnt_load, cnt_clear;
  logic                    dout_we, fv_next, err_next;
  logic                    active;

  // en is active-low: a high level freezes every piece of state.
  assign active = ~en;

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .load  (cnt_load),
    .clear (cnt_clear),
    .slot  (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Any sync while locked restarts the frame at slot 0, including at slot 3,
  // so the partial frame is dropped without touching dout.
  always_comb begin
    state_next  = state;
    shadow_next = shadow;
    miss_next   = miss_cnt;
    cnt_inc     = 1'b0;
    cnt_load    = 1'b0;
    cnt_clear   = 1'b0;
    dout_we     = 1'b0;
    fv_next     = 1'b0;
    err_next    = 1'b0;
    if (active) begin
      case (state)
        HUNT: begin
          if (sync) begin
            state_next     = LOCKED;
            shadow_next[0] = din;
            cnt_load       = 1'b1;
            miss_next      = '0;
          end
        end
        LOCKED: begin
          if (sync) begin
            shadow_next[0] = din;
            cnt_load       = 1'b1;
            miss_next      = '0;
            err_next       = (slot != '0);
          end else if (slot == '0) begin
            if (miss_cnt + MISS_CNT_W'(1) == MISS_CNT_W'(MISS_LIMIT)) begin
              state_next = HUNT;
              cnt_clear  = 1'b1;
              miss_next  = '0;
            end else begin
              shadow_next[0] = din;
              cnt_inc        = 1'b1;
              miss_next      = miss_cnt + MISS_CNT_W'(1);
            end
          end else if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
            dout_we = 1'b1;
            fv_next = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            if (slot == SLOT_W'(1)) begin
              shadow_next[1] = din;
            end else begin
              shadow_next[2] = din;
            end
            cnt_inc = 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      dout_q      <= '0;
      miss_cnt    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      shadow      <= shadow_next;
      miss_cnt    <= miss_next;
      frame_valid <= fv_next;
      sync_err    <= err_next;
      if (dout_we) begin
        dout_q <= {din, shadow};
      end
    end
  end

  assign dout_0 = dout_q[0];
  assign dout_1 = dout_q[1];
  assign dout_2 = dout_q[2];
  assign dout_3 = dout_q[3];
  assign locked = (state == LOCKED);
  assign sel_0  = locked & slot[0];
  assign sel_1  = locked & slot[1];

endmodule
